// File: rtl/button_conditioner.sv
// Button front end: 2-flop synchroniser, per-button debounce, level outputs and press pulses.
// Define BUTTON_AUTO_REPEAT_EN to add hold-to-repeat pulses on the left and right buttons.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES     = 371250,
  parameter int REPEAT_DELAY_CYCLES = 37125000,
  parameter int REPEAT_RATE_CYCLES  = 7425000
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic btnl_in,
  input  logic btnc_in,
  input  logic btnr_in,
  output logic left_out,
  output logic middle_out,
  output logic right_out,
  output logic left_press_out,
  output logic middle_press_out,
  output logic right_press_out,
  output logic any_press_out
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                           REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
  localparam int RPT_W = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE_CYCLES - 1);
  localparam logic [1:0] RELEASED  = 2'd0;
  localparam logic [1:0] HOLD_WAIT = 2'd1;
  localparam logic [1:0] REPEATING = 2'd2;
`endif

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY_CYCLES < 1 || REPEAT_RATE_CYCLES < 1) begin : g_param_check
    $error("button_conditioner: parameter out of legal range");
  end

  // Bit order everywhere: 0 = left, 1 = centre, 2 = right.
  logic [2:0] raw;
  logic [2:0] level;
  logic [2:0] press;
  logic [2:0] press_next;
  logic       any_reg;

  assign raw = {btnr_in, btnc_in, btnl_in};

  genvar gi;
  for (gi = 0; gi < 3; gi++) begin : g_btn
    logic            sync1_reg;
    logic            sync2_reg;
    logic            stable_reg;
    logic            level_reg;
    logic            press_reg;
    logic [DB_W-1:0] db_cnt_reg;

    always_ff @(posedge clk_in) begin
      if (rst_in) begin
        sync1_reg  <= 1'b0;
        sync2_reg  <= 1'b0;
        stable_reg <= 1'b0;
        level_reg  <= 1'b0;
        db_cnt_reg <= '0;
      end else begin
        sync1_reg <= raw[gi];
        sync2_reg <= sync1_reg;
        level_reg <= stable_reg;
        if (sync2_reg == stable_reg) begin
          db_cnt_reg <= '0;
        end else if (db_cnt_reg == DB_LAST) begin
          stable_reg <= ~stable_reg;
          db_cnt_reg <= '0;
        end else begin
          db_cnt_reg <= db_cnt_reg + 1'b1;
        end
      end
    end

`ifdef BUTTON_AUTO_REPEAT_EN
    if (gi != 1) begin : g_repeat
      logic [1:0]       state_reg;
      logic [1:0]       state_next;
      logic [RPT_W-1:0] rpt_cnt_reg;
      logic [RPT_W-1:0] rpt_cnt_next;
      logic             pulse_next;

      // Driven from stable/level so every pulse lands in the same cycle as the level output.
      always_comb begin
        state_next   = state_reg;
        rpt_cnt_next = rpt_cnt_reg;
        pulse_next   = 1'b0;
        case (state_reg)
          RELEASED: begin
            rpt_cnt_next = '0;
            if (stable_reg && !level_reg) begin
              pulse_next = 1'b1;
              state_next = HOLD_WAIT;
            end
          end
          HOLD_WAIT: begin
            if (!stable_reg) begin
              state_next   = RELEASED;
              rpt_cnt_next = '0;
            end else if (rpt_cnt_reg == DELAY_LAST) begin
              pulse_next   = 1'b1;
              state_next   = REPEATING;
              rpt_cnt_next = '0;
            end else begin
              rpt_cnt_next = rpt_cnt_reg + 1'b1;
            end
          end
          REPEATING: begin
            if (!stable_reg) begin
              state_next   = RELEASED;
              rpt_cnt_next = '0;
            end else if (rpt_cnt_reg == RATE_LAST) begin
              pulse_next   = 1'b1;
              rpt_cnt_next = '0;
            end else begin
              rpt_cnt_next = rpt_cnt_reg + 1'b1;
            end
          end
          default: begin
            state_next   = RELEASED;
            rpt_cnt_next = '0;
          end
        endcase
      end

      always_ff @(posedge clk_in) begin
        if (rst_in) begin
          state_reg   <= RELEASED;
          rpt_cnt_reg <= '0;
        end else begin
          state_reg   <= state_next;
          rpt_cnt_reg <= rpt_cnt_next;
        end
      end

      assign press_next[gi] = pulse_next;
    end else begin : g_single
      assign press_next[gi] = stable_reg & ~level_reg;
    end
`else
    assign press_next[gi] = stable_reg & ~level_reg;
`endif

    always_ff @(posedge clk_in) begin
      if (rst_in) begin
        press_reg <= 1'b0;
      end else begin
        press_reg <= press_next[gi];
      end
    end

    assign level[gi] = level_reg;
    assign press[gi] = press_reg;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      any_reg <= 1'b0;
    end else begin
      any_reg <= |press_next;
    end
  end

  assign left_out         = level[0];
  assign middle_out       = level[1];
  assign right_out        = level[2];
  assign left_press_out   = press[0];
  assign middle_press_out = press[1];
  assign right_press_out  = press[2];
  assign any_press_out    = any_reg;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random bouncing inputs,
// compared each cycle against a timing model of the debounce/press/repeat rules.
module tb_button_conditioner;
  localparam int DB   = 4;
  localparam int DLY  = 10;
  localparam int RATE = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btnl = 1'b0, btnc = 1'b0, btnr = 1'b0;
  logic left, middle, right, lp, mp, rp, anyp;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int base = 0;

  // reference model state (bit 0 left, 1 centre, 2 right)
  logic [2:0] q_raw[$];
  logic [2:0] m_stable = '0, m_level = '0, m_press = '0;
  int m_run[3];
  int m_start[3];

  // per-scenario observations of the DUT
  int npress[3], first_press[3], last_press[3], lvl_rise[3], lvl_fall[3];
  int nany;
  logic [2:0] prev_lvl = '0;

  // random stimulus state
  int rem[3];
  logic [2:0] rval;
  bit auto_rep;

  always #5 clk = ~clk;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY_CYCLES(DLY),
    .REPEAT_RATE_CYCLES(RATE)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .btnl_in(btnl),
    .btnc_in(btnc),
    .btnr_in(btnr),
    .left_out(left),
    .middle_out(middle),
    .right_out(right),
    .left_press_out(lp),
    .middle_press_out(mp),
    .right_press_out(rp),
    .any_press_out(anyp)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: actual 0x%0h required 0x%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit repeat_due(input int d);
    return (d == DLY) || (d > DLY && ((d - DLY) % RATE) == 0);
  endfunction

  // One clock edge of the spec rules: input lags 2 edges, D differing samples flip the
  // stable level, outputs show the level one edge later, pulses on rises and repeat times.
  task automatic model_step(input logic [2:0] raw_v, input logic r);
    logic [2:0] synced, old_level;
    if (r) begin
      q_raw.delete();
      q_raw.push_back(3'b000);
      q_raw.push_back(3'b000);
      m_stable = '0;
      m_level  = '0;
      m_press  = '0;
      for (int b = 0; b < 3; b++) m_run[b] = 0;
    end else begin
      synced = q_raw.pop_front();
      q_raw.push_back(raw_v);
      old_level = m_level;
      m_level   = m_stable;
      for (int b = 0; b < 3; b++) begin
        if (synced[b] != m_stable[b]) begin
          m_run[b]++;
          if (m_run[b] == DB) begin
            m_stable[b] = ~m_stable[b];
            m_run[b] = 0;
          end
        end else begin
          m_run[b] = 0;
        end
        m_press[b] = 1'b0;
        if (m_level[b] && !old_level[b]) begin
          m_press[b] = 1'b1;
          m_start[b] = cyc;
        end else if (auto_rep && b != 1 && m_level[b] && old_level[b] &&
                     repeat_due(cyc - m_start[b])) begin
          m_press[b] = 1'b1;
        end
      end
    end
  endtask

  task automatic clear_stats();
    base = cyc;
    nany = 0;
    for (int b = 0; b < 3; b++) begin
      npress[b] = 0; first_press[b] = -1; last_press[b] = -1;
      lvl_rise[b] = -1; lvl_fall[b] = -1;
    end
  endtask

  task automatic step(input logic [2:0] raw_v, input logic r, input string tag);
    logic [2:0] lv, pr;
    int rel;
    {btnr, btnc, btnl} = raw_v;
    rst = r;
    @(posedge clk);
    #1;
    model_step(raw_v, r);
    check(tag, {25'd0, anyp, rp, mp, lp, right, middle, left},
          {25'd0, |m_press, m_press, m_level});
    lv  = {right, middle, left};
    pr  = {rp, mp, lp};
    rel = cyc - base;
    if (anyp) nany++;
    for (int b = 0; b < 3; b++) begin
      if (pr[b]) begin
        npress[b]++;
        if (first_press[b] < 0) first_press[b] = rel;
        last_press[b] = rel;
      end
      if (lv[b] && !prev_lvl[b]) lvl_rise[b] = rel;
      if (!lv[b] && prev_lvl[b]) lvl_fall[b] = rel;
    end
    prev_lvl = lv;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(3'b000, 1'b0, "idle");
  endtask

  initial begin
`ifdef BUTTON_AUTO_REPEAT_EN
    auto_rep = 1'b1;
`else
    auto_rep = 1'b0;
`endif
    for (int b = 0; b < 3; b++) begin m_run[b] = 0; m_start[b] = 0; rem[b] = 0; end
    rval = '0;

    for (int i = 0; i < 3; i++) step(3'b111, 1'b1, "reset");
    idle(10);
    $display("reset and idle done at cycle %0d", cyc);

    // clean centre press held 20 cycles
    clear_stats();
    for (int k = 0; k < 40; k++) step((k < 20) ? 3'b010 : 3'b000, 1'b0, "clean");
    check("clean_first_press", first_press[1], 6);
    check("clean_npress", npress[1], 1);
    check("clean_rise", lvl_rise[1], 6);
    check("clean_fall", lvl_fall[1], 26);
    idle(10);
    $display("clean press scenario done at cycle %0d", cyc);

    // bouncing right button then steady high from k=10
    clear_stats();
    for (int k = 0; k < 36; k++) step((k >= 10 || (k % 2) == 0) ? 3'b100 : 3'b000, 1'b0, "bounce");
    check("bounce_first_press", first_press[2], 16);
    check("bounce_rise", lvl_rise[2], 16);
    if (!auto_rep) check("bounce_npress", npress[2], 1);
    idle(20);
    $display("bounce scenario done at cycle %0d", cyc);

    // left held 30 cycles
    clear_stats();
    for (int k = 0; k < 46; k++) step((k < 30) ? 3'b001 : 3'b000, 1'b0, "hold");
    check("hold_first_press", first_press[0], 6);
    check("hold_npress", npress[0], auto_rep ? 8 : 1);
    check("hold_last_press", last_press[0], auto_rep ? 34 : 6);
    check("hold_fall", lvl_fall[0], 36);
    idle(10);
    $display("hold scenario done at cycle %0d", cyc);

    // left and right together
    clear_stats();
    for (int k = 0; k < 22; k++) begin
      step((k < 10) ? 3'b101 : 3'b000, 1'b0, "simul");
      if (k == 6) check("simul_pulses", {anyp, rp, mp, lp}, 4'b1101);
    end
    check("simul_nany", nany, 1);
    idle(10);
    $display("simultaneous scenario done at cycle %0d", cyc);

    // reset pulse at k=18 while right held
    clear_stats();
    for (int k = 0; k < 36; k++) begin
      step(3'b100, (k == 18), "rst_hold");
      if (k == 19) check("rst_outputs_zero", {anyp, rp, mp, lp, right, middle, left}, 7'd0);
      if (k == 24) check("rst_not_yet", {rp, right}, 2'b00);
      if (k == 25) check("rst_repress", {rp, right}, 2'b11);
    end
    check("rst_rise", lvl_rise[2], 25);
    idle(20);
    $display("reset mid-hold scenario done at cycle %0d", cyc);

    // 3-cycle glitch on centre
    clear_stats();
    for (int k = 0; k < 15; k++) step((k < 3) ? 3'b010 : 3'b000, 1'b0, "glitch");
    check("glitch_npress", npress[1], 0);
    check("glitch_rise", lvl_rise[1], -1);
    $display("glitch scenario done at cycle %0d", cyc);

    // random bouncing/holding with occasional reset
    for (int n = 0; n < 4000; n++) begin
      for (int b = 0; b < 3; b++) begin
        if (rem[b] == 0) begin
          rval[b] = 1'($urandom_range(0, 1));
          rem[b]  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 40);
        end else begin
          rem[b]--;
        end
      end
      step(rval, ($urandom_range(0, 299) == 0), "random");
    end
    $display("random scenario done at cycle %0d", cyc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Front-end input stage for the UI screen controller. Takes the raw, bouncing left/centre/right push-buttons and produces clean debounced levels plus single-cycle press pulses.
- Synchronises each button to the pixel clock, debounces it with a per-button counter, and optionally auto-repeats left/right presses while the button is held.
- Outputs feed the screen controller's middle/left/right inputs directly; that controller does its own edge detection on levels.

Parameters:
- DEBOUNCE_CYCLES, 371250: consecutive cycles a synchronised input must differ from the stable level before the stable level flips (5 ms at 74.25 MHz); legal range ≥2.
- REPEAT_DELAY_CYCLES, 37125000: hold time from the initial press pulse to the first auto-repeat pulse (0.5 s); ≥1.
- REPEAT_RATE_CYCLES, 7425000: spacing between subsequent auto-repeat pulses (0.1 s); ≥1.

Ports:
- clk_in  input  1  pixel clock
- rst_in  input  1  synchronous active-high reset
- btnl_in  input  1  raw left button, asynchronous, active high
- btnc_in  input  1  raw centre button, asynchronous, active high
- btnr_in  input  1  raw right button, asynchronous, active high
- left_out  output  1  debounced left level
- middle_out  output  1  debounced centre level
- right_out  output  1  debounced right level
- left_press_out  output  1  one-cycle pulse per left press, plus auto-repeat pulses when enabled
- middle_press_out  output  1  one-cycle pulse per centre press; never repeats
- right_press_out  output  1  one-cycle pulse per right press, plus auto-repeat pulses when enabled
- any_press_out  output  1  OR of the three press pulses, registered in the same cycle as them

Behaviour:
- Clock and reset: single clock domain, clk_in. Reset is synchronous and active-high on rst_in.
- Reset values:
  - All outputs 0.
  - Synchroniser flops 0.
  - Stable levels 0.
  - All counters 0.
  - Repeat FSMs in RELEASED.
- Synchroniser: two flops per button. The synchronised value lags the raw input by 2 cycles.
- Debounce, per button, independent:
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
  - Synchronised value equals stable level: counter clears to 0.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the stable level flips on that edge and the counter clears.
  - Total latency, raw edge to level output: DEBOUNCE_CYCLES+2 cycles.
  - A glitch shorter than DEBOUNCE_CYCLES cycles produces no output change.
- Level outputs are the registered stable levels.
- Press pulse:
  - Asserted for exactly one cycle, coincident with the stable level's 0→1 transition.
  - No pulse on release.
- Repeat FSM (left and right only), states RELEASED, HOLD_WAIT, REPEATING:
  - RELEASED: on a stable 0→1 transition, emit the initial pulse, load the repeat counter with 0 and go to HOLD_WAIT.
  - HOLD_WAIT: the counter increments each cycle. On reaching REPEAT_DELAY_CYCLES-1, emit a pulse, clear the counter and go to REPEATING.
  - REPEATING: on reaching REPEAT_RATE_CYCLES-1, emit a pulse and clear the counter; stay in REPEATING.
  - Any state: stable level 0 means go to RELEASED immediately, clear the counter, and emit no pulse that cycle.
- Simultaneous buttons: fully independent; multiple press pulses in the same cycle are allowed. any_press_out is 1 if any of them is 1.
- Reset mid-hold:
  - All state returns to reset values.
  - If the button is still held after reset, it re-debounces from 0.
  - A new initial pulse then fires DEBOUNCE_CYCLES+2 cycles after reset deasserts.
- Counter arithmetic is unsigned and never wraps: counters clear before reaching 2^width.

Optional Feature:
- Macro: BUTTON_AUTO_REPEAT_EN.
- Defined: the repeat FSMs and counters are instantiated on left/right as described above.
- Undefined: no repeat logic is built. left_press_out and right_press_out carry only the initial press pulse, identical to middle_press_out. REPEAT_* parameters are accepted but ignored.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=10, REPEAT_RATE_CYCLES=3; cycle 0 is the first cycle raw is sampled high.
- Clean press of btnc_in held 20 cycles, then released:
  - middle_out rises at cycle 6.
  - middle_press_out is high at cycle 6 only.
  - middle_out falls 6 cycles after release.
  - No further pulses, including with BUTTON_AUTO_REPEAT_EN defined.
- Bounce on btnr_in: 1-cycle high, 1-cycle low pulses for 10 cycles, then steady high:
  - No pulse during the bouncing.
  - Single right_press_out 6 cycles after the steady high begins.
- btnl_in held 30 cycles with BUTTON_AUTO_REPEAT_EN defined:
  - left_press_out pulses at cycles 6, 16, 19, 22, 25, 28, 31, 34. Cycles 31 and 34 fall after the cycle-30 release but before left_out drops at cycle 36.
  - No pulse after left_out drops.
  - Without the macro: pulse at cycle 6 only.
- btnl_in and btnr_in raised in the same cycle:
  - left_press_out and right_press_out both pulse at cycle 6.
  - any_press_out is high at cycle 6 for one cycle.
- rst_in asserted for 1 cycle at cycle 18 while btnr_in is held:
  - All outputs are 0 at cycle 19.
  - right_out and right_press_out reassert at cycle 25.
- Glitch: btnc_in high for 3 cycles only → middle_out and middle_press_out stay 0 throughout.
